mm_seq: RTL and testbench

MM_SEQ -- requirements
Module: mm_seq

---
 rtl/mm_seq.sv | 160 ++++++++++++++++
 tb/tb_mm_seq.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mm_seq.sv
// Matrix-multiply sequencer: walks C = A*B over a shared BRAM and drives an external MAC.
// Latency N*N*(3N+3)+1 cycles from start to done with the grant held high; ungranted requests stall in place.
module mm_seq #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              cfg_start,
  input  logic [ADDR_W-1:0] cfg_base_a,
  input  logic [ADDR_W-1:0] cfg_base_b,
  input  logic [ADDR_W-1:0] cfg_base_c,
  input  logic [2:0]        cfg_n,
  output logic              busy,
  output logic              done,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mac_clr,
  output logic              mac_en,
  output logic [DATA_W-1:0] mac_a,
  output logic [DATA_W-1:0] mac_b,
  input  logic [DATA_W-1:0] mac_acc
);

  typedef enum logic [2:0] {IDLE, CLR, RD_A, RD_B, MAC, ACC, WR_C, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] base_a, base_b, base_c;
  logic [2:0]        n_reg;
  logic [1:0]        i, j, k;
  logic [ADDR_W-1:0] row_off;   // i*N, shared by the A and C address
  logic [ADDR_W-1:0] k_off;     // k*N for the B address
  logic [DATA_W-1:0] a_reg, c_reg;
  logic              a_first;
  logic [2:0]        n_eff;
  logic              last_k, last_j, last_i;
  logic [ADDR_W-1:0] n_ext, k_ext, j_ext;

  assign n_eff  = (cfg_n == 3'd0 || cfg_n > 3'd4) ? 3'd4 : cfg_n;
  assign last_k = ({1'b0, k} == n_reg - 3'd1);
  assign last_j = ({1'b0, j} == n_reg - 3'd1);
  assign last_i = ({1'b0, i} == n_reg - 3'd1);
  assign n_ext  = ADDR_W'(n_reg);
  assign k_ext  = ADDR_W'(k);
  assign j_ext  = ADDR_W'(j);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state   <= IDLE;
      base_a  <= '0;
      base_b  <= '0;
      base_c  <= '0;
      n_reg   <= '0;
      i       <= '0;
      j       <= '0;
      k       <= '0;
      row_off <= '0;
      k_off   <= '0;
      a_reg   <= '0;
      c_reg   <= '0;
      a_first <= 1'b0;
    end else begin
      state   <= state_nxt;
      // The A word arrives the cycle after its read is granted: first cycle of RD_B.
      a_first <= (state == RD_A) && mem_gnt;
      if (a_first) a_reg <= mem_rdata;
      case (state)
        IDLE: if (cfg_start) begin
          base_a  <= cfg_base_a;
          base_b  <= cfg_base_b;
          base_c  <= cfg_base_c;
          n_reg   <= n_eff;
          i       <= '0;
          j       <= '0;
          k       <= '0;
          row_off <= '0;
          k_off   <= '0;
        end
        MAC: if (last_k) begin
          k     <= '0;
          k_off <= '0;
        end else begin
          k     <= k + 2'd1;
          k_off <= k_off + n_ext;
        end
        ACC: c_reg <= mac_acc;
        WR_C: if (mem_gnt) begin
          if (last_j) begin
            j <= '0;
            if (last_i) begin
              i       <= '0;
              row_off <= '0;
            end else begin
              i       <= i + 2'd1;
              row_off <= row_off + n_ext;
            end
          end else begin
            j <= j + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done      = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mac_clr   = 1'b0;
    mac_en    = 1'b0;
    mac_a     = '0;
    mac_b     = '0;
    case (state)
      IDLE: if (cfg_start) state_nxt = CLR;
      CLR: begin
        mac_clr   = 1'b1;
        state_nxt = RD_A;
      end
      RD_A: begin
        mem_req  = 1'b1;
        mem_addr = base_a + row_off + k_ext;
        if (mem_gnt) state_nxt = RD_B;
      end
      RD_B: begin
        mem_req  = 1'b1;
        mem_addr = base_b + k_off + j_ext;
        if (mem_gnt) state_nxt = MAC;
      end
      MAC: begin
        mac_en    = 1'b1;
        mac_a     = a_reg;
        mac_b     = mem_rdata;
        state_nxt = last_k ? ACC : RD_A;
      end
      ACC: state_nxt = WR_C;
      WR_C: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = base_c + row_off + j_ext;
        mem_wdata = c_reg;
        if (mem_gnt) state_nxt = (last_i && last_j) ? DONE : CLR;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mm_seq.sv
// Bench for mm_seq: BRAM and MAC models around the DUT, a queue of expected memory accesses built
// from plain matrix arithmetic, and a per-cycle compare process.
module tb_mm_seq;
  localparam int AW = 12;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_start;
  logic [AW-1:0] ba, bb, bc;
  logic [2:0]    cfg_n;
  logic          busy, done, mem_req, mem_we, mac_clr, mac_en;
  logic          mem_gnt = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mac_a, mac_b;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW-1:0] mac_acc = '0;

  always #5 clk = ~clk;

  mm_seq #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .cfg_start(cfg_start),
    .cfg_base_a(ba), .cfg_base_b(bb), .cfg_base_c(bc), .cfg_n(cfg_n),
    .busy(busy), .done(done), .mem_req(mem_req), .mem_gnt(mem_gnt),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mac_clr(mac_clr), .mac_en(mac_en), .mac_a(mac_a), .mac_b(mac_b), .mac_acc(mac_acc)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // BRAM model with a backdoor port for loading, plus the external MAC.
  logic [DW-1:0] mem [0:4095];
  logic          bd_we = 1'b0, bd_clr = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [DW-1:0] bd_data = '0;
  int            wr_cnt = 0;

  always @(posedge clk) begin
    if (bd_clr) begin
      for (int a = 0; a < 4096; a++) mem[a] <= '0;
    end else if (bd_we) begin
      mem[bd_addr] <= bd_data;
    end else if (mem_req && mem_gnt) begin
      if (mem_we) begin
        mem[mem_addr] <= mem_wdata;
        wr_cnt <= wr_cnt + 1;
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
    if (mac_clr) mac_acc <= '0;
    else if (mac_en) mac_acc <= mac_acc + mac_a * mac_b;
  end

  // Grant pattern: 0 = always, 1 = random, 2 = grant reads only.
  int gmode = 0;
  initial forever begin
    @(posedge clk);
    #1;
    case (gmode)
      0: mem_gnt = 1'b1;
      1: mem_gnt = 1'($urandom_range(0, 1));
      2: mem_gnt = !mem_we;
      default: mem_gnt = 1'b0;
    endcase
  end

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } acc_t;
  acc_t          expq[$];
  logic [DW-1:0] exp_c [16];
  int            n_model;

  // Expected access stream: for each C element, the N (A,B) read pairs then the write of the dot product.
  task automatic build_model(input logic [2:0] n_cfg, input logic [AW-1:0] a0, b0, c0);
    logic [DW-1:0] sum, av, bv;
    logic [AW-1:0] aa, ab;
    acc_t e;
    n_model = (n_cfg >= 3'd1 && n_cfg <= 3'd4) ? int'(n_cfg) : 4;
    expq.delete();
    for (int r = 0; r < n_model; r++)
      for (int c = 0; c < n_model; c++) begin
        sum = '0;
        for (int x = 0; x < n_model; x++) begin
          aa = a0 + AW'(r * n_model + x);
          ab = b0 + AW'(x * n_model + c);
          av = mem[aa];
          bv = mem[ab];
          sum = sum + av * bv;
          e = '{we: 1'b0, addr: aa, data: '0};
          expq.push_back(e);
          e = '{we: 1'b0, addr: ab, data: '0};
          expq.push_back(e);
        end
        exp_c[r * n_model + c] = sum;
        e = '{we: 1'b1, addr: c0 + AW'(r * n_model + c), data: sum};
        expq.push_back(e);
      end
  endtask

  // Per-cycle compare against the model and the output rules.
  initial begin
    acc_t          e;
    logic          prev_stall = 1'b0, prev_rst = 1'b1, prev_we = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [DW-1:0] prev_wdata = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (prev_stall && !prev_rst) begin
          chk("stall_req", mem_req, 1);
          chk("stall_addr", mem_addr, prev_addr);
          chk("stall_we", mem_we, prev_we);
          chk("stall_wdata", mem_wdata, prev_wdata);
          chk("stall_mac_en", mac_en, 0);
        end
        if (!mem_req) begin
          chk("idle_addr", mem_addr, 0);
          chk("idle_we", mem_we, 0);
        end
        if (!(mem_req && mem_we)) chk("idle_wdata", mem_wdata, 0);
        if (!mac_en) begin
          chk("idle_mac_a", mac_a, 0);
          chk("idle_mac_b", mac_b, 0);
        end
        if (mem_req && mem_gnt) begin
          if (expq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL access_unexpected: got addr 0x%0h we %0b, expected no access", mem_addr, mem_we);
          end else begin
            e = expq.pop_front();
            chk("acc_we", mem_we, e.we);
            chk("acc_addr", mem_addr, e.addr);
            if (e.we) chk("acc_wdata", mem_wdata, e.data);
          end
        end
      end
      prev_stall = mem_req && !mem_gnt && !rst;
      prev_rst   = rst;
      prev_addr  = mem_addr;
      prev_we    = mem_we;
      prev_wdata = mem_wdata;
    end
  end

  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bd_addr = a;
    bd_data = d;
    bd_we   = 1'b1;
    @(negedge clk);
    bd_we   = 1'b0;
  endtask

  task automatic clear_mem();
    bd_clr = 1'b1;
    @(negedge clk);
    bd_clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    expq.delete();
  endtask

  task automatic pulse_start(input logic [2:0] n_cfg, input logic [AW-1:0] a0, b0, c0);
    cfg_n     = n_cfg;
    ba        = a0;
    bb        = b0;
    bc        = c0;
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  // Runs one matmul; returns the done cycle (-1 on timeout). With poke set, a second start with
  // different bases is attempted mid-run.
  task automatic run_mm(input logic [2:0] n_cfg, input logic [AW-1:0] a0, b0, c0,
                        input int gm, input bit poke_start, output int done_at);
    int c, w0, n;
    @(negedge clk);
    build_model(n_cfg, a0, b0, c0);
    n       = n_model;
    gmode   = gm;
    w0      = wr_cnt;
    done_at = -1;
    pulse_start(n_cfg, a0, b0, c0);
    c = 1;
    while (c < 5000) begin
      if (done) begin
        done_at = c;
        break;
      end
      chk("busy_run", busy, 1);
      if (poke_start && c == 50) begin
        cfg_start = 1'b1;
        ba = a0 + 12'h200;
        bb = b0 + 12'h200;
        bc = c0 + 12'h200;
        cfg_n = 3'd1;
      end
      if (poke_start && c == 51) cfg_start = 1'b0;
      @(negedge clk);
      c++;
    end
    cfg_start = 1'b0;
    if (done_at < 0) begin
      checks++;
      failures++;
      $display("FAIL run_timeout: got no done within %0d cycles, expected done", c);
      do_reset();
    end else begin
      if (gm == 0) chk("done_cycle_model", done_at, n * n * (3 * n + 3) + 1);
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      chk("busy_after", busy, 0);
      chk("queue_drained", expq.size(), 0);
      chk("write_count", wr_cnt - w0, n * n);
      for (int r = 0; r < n * n; r++)
        chk("c_mem", mem[c0 + AW'(r)], exp_c[r]);
    end
    gmode = 0;
  endtask

  initial begin
    int d;
    logic [AW-1:0] ra, rb, rc;
    logic [2:0] rn;
    int rneff;
    cfg_start = 1'b0;
    ba = '0;
    bb = '0;
    bc = '0;
    cfg_n = '0;
    clear_mem();
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_clr", mac_clr, 0);
    chk("rst_mac_en", mac_en, 0);
    chk("rst_mac_a", mac_a, 0);
    chk("rst_mac_b", mac_b, 0);
    rst = 1'b0;

    // Identity times 0..15, N=4.
    for (int r = 0; r < 16; r++) begin
      poke(12'h000 + AW'(r), (r / 4 == r % 4) ? 32'd1 : 32'd0);
      poke(12'h010 + AW'(r), DW'(r));
    end
    run_mm(3'd4, 12'h000, 12'h010, 12'h020, 0, 1'b0, d);
    chk("id_done_241", d, 241);
    for (int r = 0; r < 16; r++) chk("id_c", mem[12'h020 + AW'(r)], r);

    // 2x2 literal case, then the same with a random grant.
    poke(12'h040, 1); poke(12'h041, 2); poke(12'h042, 3); poke(12'h043, 4);
    poke(12'h050, 5); poke(12'h051, 6); poke(12'h052, 7); poke(12'h053, 8);
    run_mm(3'd2, 12'h040, 12'h050, 12'h060, 0, 1'b0, d);
    chk("n2_done_37", d, 37);
    chk("n2_c00", mem[12'h060], 19);
    chk("n2_c01", mem[12'h061], 22);
    chk("n2_c10", mem[12'h062], 43);
    chk("n2_c11", mem[12'h063], 50);
    run_mm(3'd2, 12'h040, 12'h050, 12'h070, 1, 1'b0, d);
    chk("rg_c00", mem[12'h070], 19);
    chk("rg_c01", mem[12'h071], 22);
    chk("rg_c10", mem[12'h072], 43);
    chk("rg_c11", mem[12'h073], 50);

    // cfg_n=0 acts as 4; a mid-run start with other bases is ignored.
    for (int r = 0; r < 16; r++) begin
      poke(12'h080 + AW'(r), $urandom);
      poke(12'h090 + AW'(r), $urandom);
    end
    run_mm(3'd0, 12'h080, 12'h090, 12'h0A0, 0, 1'b1, d);
    chk("n0_done_241", d, 241);
    chk("poke_c_untouched0", mem[12'h2A0], 0);
    chk("poke_c_untouched1", mem[12'h2A1], 0);

    // Address wrap of the C base.
    poke(12'h100, 1); poke(12'h101, 2); poke(12'h102, 3); poke(12'h103, 4);
    poke(12'h110, 5); poke(12'h111, 6); poke(12'h112, 7); poke(12'h113, 8);
    run_mm(3'd2, 12'h100, 12'h110, 12'hFFE, 0, 1'b0, d);
    chk("wrap_ffe", mem[12'hFFE], 19);
    chk("wrap_fff", mem[12'hFFF], 22);
    chk("wrap_000", mem[12'h000], 43);
    chk("wrap_001", mem[12'h001], 50);

    // Random runs: random N, bases in disjoint windows, random data and grant.
    for (int t = 0; t < 4; t++) begin
      rn = 3'($urandom_range(0, 7));
      ra = AW'($urandom_range(12'h200, 12'h3F0));
      rb = AW'($urandom_range(12'h400, 12'h5F0));
      rc = AW'($urandom_range(12'h600, 12'h7F0));
      rneff = (rn >= 3'd1 && rn <= 3'd4) ? int'(rn) : 4;
      for (int r = 0; r < rneff * rneff; r++) begin
        poke(ra + AW'(r), $urandom);
        poke(rb + AW'(r), $urandom);
      end
      run_mm(rn, ra, rb, rc, int'($urandom_range(0, 1)), 1'b0, d);
    end

    // Reset while a write is stalled, then a 1x1 run from reset.
    @(negedge clk);
    build_model(3'd2, 12'h100, 12'h110, 12'h380);
    gmode = 2;
    pulse_start(3'd2, 12'h100, 12'h110, 12'h380);
    d = 0;
    while (d < 200 && !(mem_req && mem_we)) begin
      @(negedge clk);
      d++;
    end
    chk("reach_wr_c", mem_req && mem_we, 1);
    repeat (2) @(negedge clk);
    d = wr_cnt;
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rstwr_busy", busy, 0);
    chk("rstwr_req", mem_req, 0);
    chk("rstwr_we", mem_we, 0);
    chk("rstwr_done", done, 0);
    #1 rst = 1'b0;
    gmode = 0;
    expq.delete();
    @(negedge clk);
    chk("rstwr_no_write", wr_cnt, d);
    chk("rstwr_c_untouched", mem[12'h380], 0);
    poke(12'h300, 3);
    poke(12'h301, 5);
    run_mm(3'd1, 12'h300, 12'h301, 12'h302, 0, 1'b0, d);
    chk("n1_done_7", d, 7);
    chk("n1_c", mem[12'h302], 15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
